spi_display_tx: RTL and testbench



---
 rtl/spi_display_tx_if.sv | 17 +
 rtl/spi_display_tx.sv | 169 ++++++++++++++++
 tb/tb_spi_display_tx.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_display_tx_if.sv
// Word bus from the SoC into spi_display_tx.
//   tx_valid/tx_ready : a word transfers on valid & ready at a clk rising edge
//   tx_data           : word, left-aligned; bits [31:32-N] are sent, bit 31 first
//   tx_len            : word length, 0=8, 1=16, 2=24, 3=32 bits
//   tx_dc             : level driven on dc while this word is sent
//   tx_last           : 1 releases csn after this word, 0 keeps csn low for the next
interface spi_display_tx_if;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic [1:0]  tx_len;
   logic        tx_dc;
   logic        tx_last;

   modport master (output tx_valid, tx_data, tx_len, tx_dc, tx_last, input tx_ready);
   modport slave  (input tx_valid, tx_data, tx_len, tx_dc, tx_last, output tx_ready);
endinterface

// File: rtl/spi_display_tx.sv
// SPI mode-0 master serializer for the display link. Words of 8/16/24/32 bits
// arrive over the tx bus and leave MSB-first on spi_sdo; linked words share one
// chip-select, and dc carries a per-word data/command flag.
//   clk, resetn : system clock, asynchronous active-low reset
//   tx          : word bus (slave side), see spi_display_tx_if
//   spi_sclk    : serial clock, idle low
//   spi_sdo     : serial data, changes only while spi_sclk is low
//   dc          : data/command flag, updated at word acceptance
//   csn         : chip select, active low
//   busy        : high while csn is low or the csn-high idle window runs
// Timing parameters are in clk cycles and must fit in a 16-bit counter.
module spi_display_tx #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_IDLE  = 2
) (
   input  logic             clk,
   input  logic             resetn,
   spi_display_tx_if.slave  tx,
   output logic             spi_sclk,
   output logic             spi_sdo,
   output logic             dc,
   output logic             csn,
   output logic             busy
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LINK, CSIDLE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [30:0]      shreg;      // bits still to send below the one on spi_sdo
   logic [4:0]       bit_cnt;
   logic [4:0]       last_bit;   // N-1
   logic             last;
   logic             accept;

   assign accept = tx.tx_valid & tx.tx_ready;

   // Frame sequencer; every output is a register of this block
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         shreg       <= '0;
         bit_cnt     <= '0;
         last_bit    <= '0;
         last        <= 1'b0;
         tx.tx_ready <= 1'b0;
         spi_sclk    <= 1'b0;
         spi_sdo     <= 1'b0;
         dc          <= 1'b0;
         csn         <= 1'b1;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx.tx_ready <= 1'b1;
               if (accept) begin
                  shreg       <= tx.tx_data[30:0];
                  spi_sdo     <= tx.tx_data[31];
                  last_bit    <= {tx.tx_len, 3'b111};
                  dc          <= tx.tx_dc;
                  last        <= tx.tx_last;
                  bit_cnt     <= '0;
                  cnt         <= '0;
                  csn         <= 1'b0;
                  busy        <= 1'b1;
                  tx.tx_ready <= 1'b0;
                  state       <= SETUP;
               end
            end

            SETUP: begin
               if (cnt == CNT_W'(CS_SETUP - 1)) begin
                  cnt   <= '0;
                  state <= SHIFT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Low phase then high phase per bit; data moves on the falling edge
            SHIFT: begin
               if (cnt != CNT_W'(CLK_DIV - 1)) begin
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  cnt <= '0;
                  if (!spi_sclk) begin
                     spi_sclk <= 1'b1;
                  end else begin
                     spi_sclk <= 1'b0;
                     shreg    <= {shreg[29:0], 1'b0};
                     spi_sdo  <= shreg[30];
                     bit_cnt  <= bit_cnt + 5'd1;
                     if (bit_cnt == last_bit) begin
                        if (!last) begin
                           tx.tx_ready <= 1'b1;
                           state       <= LINK;
                        end else if (CS_HOLD == 0) begin
                           // No hold window: release csn on the last falling edge
                           csn     <= 1'b1;
                           spi_sdo <= 1'b0;
                           if (CS_IDLE == 0) begin
                              tx.tx_ready <= 1'b1;
                              busy        <= 1'b0;
                              state       <= IDLE;
                           end else begin
                              state <= CSIDLE;
                           end
                        end else begin
                           state <= HOLD;
                        end
                     end
                  end
               end
            end

            HOLD: begin
               if (cnt == CNT_W'(CS_HOLD - 1)) begin
                  cnt     <= '0;
                  csn     <= 1'b1;
                  spi_sdo <= 1'b0;
                  if (CS_IDLE == 0) begin
                     tx.tx_ready <= 1'b1;
                     busy        <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     state <= CSIDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // csn stays low; the next word's first low phase doubles as setup
            LINK: begin
               if (accept) begin
                  shreg       <= tx.tx_data[30:0];
                  spi_sdo     <= tx.tx_data[31];
                  last_bit    <= {tx.tx_len, 3'b111};
                  dc          <= tx.tx_dc;
                  last        <= tx.tx_last;
                  bit_cnt     <= '0;
                  cnt         <= '0;
                  tx.tx_ready <= 1'b0;
                  state       <= SHIFT;
               end
            end

            CSIDLE: begin
               if (cnt == CNT_W'(CS_IDLE - 1)) begin
                  cnt         <= '0;
                  tx.tx_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_display_tx.sv
// Self-checking bench for spi_display_tx: a default-parameter instance exercised
// through a receiver scoreboard, plus a fast-timing instance for edge parameters.
module tb_spi_display_tx;

   typedef struct {
      logic [31:0] data;
      int          n;
      logic        dc;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;

   spi_display_tx_if bus0 ();
   spi_display_tx_if bus1 ();

   logic sclk0, sdo0, dc0, csn0, busy0;
   logic sclk1, sdo1, dc1, csn1, busy1;

   int checks = 0;
   int errors = 0;

   exp_t q0[$];
   exp_t q1[$];

   int          rise_cnt0     = 0;
   int          csn_rise_cnt0 = 0;
   int          bitpos0       = 0;
   logic [31:0] rx0           = '0;
   logic        prev_sclk0    = 1'b0;
   logic        prev_csn0     = 1'b1;
   logic        prev_sdo0     = 1'b0;
   logic        prev_dc0      = 1'b0;

   always #5 clk = ~clk;

   spi_display_tx u_dut0 (
      .clk      (clk),
      .resetn   (resetn),
      .tx       (bus0),
      .spi_sclk (sclk0),
      .spi_sdo  (sdo0),
      .dc       (dc0),
      .csn      (csn0),
      .busy     (busy0)
   );

   spi_display_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(0), .CS_IDLE(2)) u_dut1 (
      .clk      (clk),
      .resetn   (resetn),
      .tx       (bus1),
      .spi_sclk (sclk1),
      .spi_sdo  (sdo1),
      .dc       (dc1),
      .csn      (csn1),
      .busy     (busy1)
   );

   function automatic logic [31:0] mask_word(input logic [31:0] d, input int n);
      logic [31:0] m;
      m = '1;
      m = m << (32 - n);
      return d & m;
   endfunction

   // Far-end receiver for instance 0: samples spi_sdo at each spi_sclk rise
   always @(negedge clk) begin
      if (!resetn) begin
         q0.delete();
         bitpos0    = 0;
         rx0        = '0;
         prev_sclk0 = 1'b0;
         prev_csn0  = 1'b1;
         prev_sdo0  = 1'b0;
         prev_dc0   = 1'b0;
      end else begin
         if (sclk0 && !prev_sclk0) begin
            rise_cnt0++;
            checks++;
            if (csn0 !== 1'b0) begin
               errors++;
               $display("FAIL rx_csn_at_rise: csn=%b, required 0", csn0);
            end else if (q0.size() == 0) begin
               errors++;
               $display("FAIL rx_unexpected_bit: got a rising edge with no word expected, required none");
            end else begin
               rx0[31 - bitpos0] = sdo0;
               bitpos0++;
               if (dc0 !== q0[0].dc) begin
                  errors++;
                  $display("FAIL rx_dc: dc=%b at bit %0d, required %b", dc0, bitpos0, q0[0].dc);
               end
               if (bitpos0 == q0[0].n) begin
                  checks++;
                  if (rx0 !== mask_word(q0[0].data, q0[0].n)) begin
                     errors++;
                     $display("FAIL rx_word: received %h, required %h", rx0,
                              mask_word(q0[0].data, q0[0].n));
                  end
                  void'(q0.pop_front());
                  bitpos0 = 0;
                  rx0     = '0;
               end
            end
         end
         if (sclk0 && prev_sclk0) begin
            checks++;
            if (sdo0 !== prev_sdo0 || dc0 !== prev_dc0) begin
               errors++;
               $display("FAIL stable_while_high: sdo=%b dc=%b, required sdo=%b dc=%b",
                        sdo0, dc0, prev_sdo0, prev_dc0);
            end
         end
         if (csn0 && !prev_csn0) csn_rise_cnt0++;
         prev_sclk0 = sclk0;
         prev_csn0  = csn0;
         prev_sdo0  = sdo0;
         prev_dc0   = dc0;
      end
   end

   // Offer one word on bus0 and wait (bounded) for its handshake
   task automatic send0(input logic [31:0] data, input logic [1:0] len, input logic dcv,
                        input logic lastv, input bit hold, output int waited);
      exp_t e;
      @(negedge clk);
      bus0.tx_valid = 1'b1;
      bus0.tx_data  = data;
      bus0.tx_len   = len;
      bus0.tx_dc    = dcv;
      bus0.tx_last  = lastv;
      e.data = data;
      e.n    = 8 * (int'(len) + 1);
      e.dc   = dcv;
      q0.push_back(e);
      waited = 0;
      while (!bus0.tx_ready && waited < 5000) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (bus0.tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL send0_handshake: tx_ready=%b after %0d cycles, required 1",
                  bus0.tx_ready, waited);
      end else begin
         @(posedge clk);
         #1;
      end
      if (!hold) bus0.tx_valid = 1'b0;
   endtask

   // Cycles csn stays low after a handshake, then cycles busy outlasts csn
   task automatic measure0(output int low, output int idle);
      low  = 0;
      idle = 0;
      @(negedge clk);
      while (!csn0 && low < 5000) begin
         low++;
         @(negedge clk);
      end
      while (busy0 && idle < 100) begin
         idle++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      resetn        = 1'b0;
      bus0.tx_valid = 1'b0;
      bus0.tx_data  = '0;
      bus0.tx_len   = '0;
      bus0.tx_dc    = 1'b0;
      bus0.tx_last  = 1'b0;
      bus1.tx_valid = 1'b0;
      bus1.tx_data  = '0;
      bus1.tx_len   = '0;
      bus1.tx_dc    = 1'b0;
      bus1.tx_last  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({csn0, sclk0, sdo0, dc0, bus0.tx_ready, busy0} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_outputs: csn,sclk,sdo,dc,ready,busy=%b, required 100000",
                  {csn0, sclk0, sdo0, dc0, bus0.tx_ready, busy0});
      end
      resetn = 1'b1;
      checks++;
      if (bus0.tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready: tx_ready=%b, required 0", bus0.tx_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus0.tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_release: tx_ready=%b, required 1", bus0.tx_ready);
      end
   endtask

   task automatic test_single_word();
      int w, low, idle;
      rise_cnt0 = 0;
      send0(32'hA5C3_0F81, 2'd3, 1'b1, 1'b1, 1'b0, w);
      measure0(low, idle);
      checks++;
      if (low != 260) begin errors++; $display("FAIL single_csn_low: %0d cycles, required 260", low); end
      checks++;
      if (idle != 2) begin errors++; $display("FAIL single_busy_tail: %0d cycles, required 2", idle); end
      checks++;
      if (rise_cnt0 != 32) begin errors++; $display("FAIL single_rises: %0d, required 32", rise_cnt0); end
      checks++;
      if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready: %b, required 1", bus0.tx_ready); end
      checks++;
      if (q0.size() != 0) begin errors++; $display("FAIL single_drain: %0d words pending, required 0", q0.size()); end
   endtask

   task automatic test_short_word();
      int w, low, idle;
      rise_cnt0 = 0;
      send0(32'h3C00_0000, 2'd0, 1'b0, 1'b1, 1'b0, w);
      measure0(low, idle);
      checks++;
      if (low != 68) begin errors++; $display("FAIL short_csn_low: %0d cycles, required 68", low); end
      checks++;
      if (rise_cnt0 != 8) begin errors++; $display("FAIL short_rises: %0d, required 8", rise_cnt0); end
      checks++;
      if (idle != 2) begin errors++; $display("FAIL short_busy_tail: %0d cycles, required 2", idle); end
   endtask

   task automatic test_linked_burst();
      int w1, w2, low, idle;
      rise_cnt0     = 0;
      csn_rise_cnt0 = 0;
      send0(32'h2A00_0000, 2'd0, 1'b0, 1'b0, 1'b1, w1);
      send0(32'h0012_0034, 2'd3, 1'b1, 1'b1, 1'b0, w2);
      checks++;
      if (w2 != 66) begin errors++; $display("FAIL link_accept_wait: %0d cycles, required 66", w2); end
      measure0(low, idle);
      checks++;
      if (low != 258) begin errors++; $display("FAIL link_second_csn_low: %0d cycles, required 258", low); end
      checks++;
      if (rise_cnt0 != 40) begin errors++; $display("FAIL link_rises: %0d, required 40", rise_cnt0); end
      checks++;
      if (csn_rise_cnt0 != 1) begin errors++; $display("FAIL link_csn_rises: %0d, required 1", csn_rise_cnt0); end
   endtask

   task automatic test_back_pressure();
      int w1, w2, low, idle;
      rise_cnt0 = 0;
      send0(32'hC001_D00D, 2'd3, 1'b1, 1'b1, 1'b0, w1);
      send0(32'h6B5A_4321, 2'd2, 1'b0, 1'b1, 1'b0, w2);
      checks++;
      if (w2 != 262) begin errors++; $display("FAIL bp_accept_wait: %0d cycles, required 262", w2); end
      measure0(low, idle);
      checks++;
      if (low != 196) begin errors++; $display("FAIL bp_csn_low: %0d cycles, required 196", low); end
      checks++;
      if (rise_cnt0 != 56) begin errors++; $display("FAIL bp_rises: %0d, required 56", rise_cnt0); end
   endtask

   task automatic test_link_stall();
      int w, n, bad, low, idle;
      send0(32'h8100_0000, 2'd0, 1'b0, 1'b0, 1'b0, w);
      n = 0;
      while (!bus0.tx_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL stall_ready: %b, required 1", bus0.tx_ready); end
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (csn0 !== 1'b0 || sclk0 !== 1'b0 || busy0 !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_lines: %0d bad cycles, required 0", bad); end
      send0(32'hBEEF_0000, 2'd1, 1'b1, 1'b1, 1'b0, w);
      measure0(low, idle);
      checks++;
      if (low != 130) begin errors++; $display("FAIL stall_tail_csn_low: %0d cycles, required 130", low); end
      checks++;
      if (idle != 2) begin errors++; $display("FAIL stall_busy_tail: %0d cycles, required 2", idle); end
   endtask

   task automatic test_mid_frame_reset();
      int w, n, low, idle;
      rise_cnt0 = 0;
      send0(32'hDEAD_BEEF, 2'd3, 1'b1, 1'b1, 1'b0, w);
      n = 0;
      while (rise_cnt0 < 10 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rise_cnt0 != 10) begin errors++; $display("FAIL rst_bits_before: %0d, required 10", rise_cnt0); end
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if ({csn0, sclk0, sdo0, bus0.tx_ready, busy0} !== 5'b10000) begin
         errors++;
         $display("FAIL rst_async_outputs: csn,sclk,sdo,ready,busy=%b, required 10000",
                  {csn0, sclk0, sdo0, bus0.tx_ready, busy0});
      end
      repeat (3) @(negedge clk);
      resetn    = 1'b1;
      rise_cnt0 = 0;
      send0(32'h1234_5678, 2'd3, 1'b0, 1'b1, 1'b0, w);
      measure0(low, idle);
      checks++;
      if (low != 260) begin errors++; $display("FAIL rst_after_csn_low: %0d cycles, required 260", low); end
      checks++;
      if (rise_cnt0 != 32) begin errors++; $display("FAIL rst_after_rises: %0d, required 32", rise_cnt0); end
      checks++;
      if (q0.size() != 0) begin errors++; $display("FAIL rst_after_drain: %0d words pending, required 0", q0.size()); end
   endtask

   task automatic test_edge_params();
      exp_t        e;
      logic [31:0] rx;
      logic        ps;
      int          n, low, rises, bad_period, last_rise;
      e.data = 32'h5A3C_96E1;
      e.n    = 32;
      e.dc   = 1'b0;
      q1.push_back(e);
      @(negedge clk);
      bus1.tx_valid = 1'b1;
      bus1.tx_data  = e.data;
      bus1.tx_len   = 2'd3;
      bus1.tx_dc    = e.dc;
      bus1.tx_last  = 1'b1;
      n = 0;
      while (!bus1.tx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus1.tx_ready !== 1'b1) begin errors++; $display("FAIL edge_ready: %b, required 1", bus1.tx_ready); end
      @(posedge clk);
      #1;
      bus1.tx_valid = 1'b0;
      low        = 0;
      rises      = 0;
      bad_period = 0;
      last_rise  = -1;
      ps         = 1'b0;
      rx         = '0;
      @(negedge clk);
      while (!csn1 && low < 1000) begin
         low++;
         if (sclk1 && !ps) begin
            if (rises < 32) rx[31 - rises] = sdo1;
            if (last_rise >= 0 && (low - last_rise) != 2) bad_period++;
            last_rise = low;
            rises++;
         end
         ps = sclk1;
         @(negedge clk);
      end
      e = q1.pop_front();
      checks++;
      if (low != 65) begin errors++; $display("FAIL edge_csn_low: %0d cycles, required 65", low); end
      checks++;
      if (rises != 32) begin errors++; $display("FAIL edge_rises: %0d, required 32", rises); end
      checks++;
      if (bad_period != 0) begin errors++; $display("FAIL edge_sclk_period: %0d bad periods, required 0", bad_period); end
      checks++;
      if (rx !== mask_word(e.data, e.n)) begin
         errors++;
         $display("FAIL edge_word: received %h, required %h", rx, mask_word(e.data, e.n));
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_short_word();
      test_linked_burst();
      test_back_pressure();
      test_link_stall();
      test_mid_frame_reset();
      test_edge_params();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
